// File: rtl/iir_pkg.sv
// Shared definitions for the IIR run controller: widths, coefficient map and FSM states.
package iir_pkg;

   localparam int DW    = 12;
   localparam int NCOEF = 5;
   localparam int AW    = 3;

   localparam logic [AW-1:0] COEF_B0 = 3'd0;
   localparam logic [AW-1:0] COEF_B1 = 3'd1;
   localparam logic [AW-1:0] COEF_B2 = 3'd2;
   localparam logic [AW-1:0] COEF_A1 = 3'd3;
   localparam logic [AW-1:0] COEF_A2 = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN,
      ST_FIN
   } state_t;

endpackage

// File: rtl/iir_ctrl_if.sv
// Bundle of configuration, run-control, source and filter-side signals of iir_ctrl.
interface iir_ctrl_if
   import iir_pkg::*;
#(
   parameter int DW    = iir_pkg::DW,
   parameter int NCOEF = iir_pkg::NCOEF,
   parameter int CNT_W = 16
) ();

   logic                CFG_WE;
   logic [AW-1:0]       CFG_ADDR;
   logic [DW-1:0]       CFG_DATA;
   logic                CFG_ERR;
   logic [NCOEF*DW-1:0] COEF;
   logic                START;
   logic                ABORT;
   logic [CNT_W-1:0]    NSAMP;
   logic                SRC_VALID;
   logic [DW-1:0]       SRC_DATA;
   logic                SRC_READY;
   logic [DW-1:0]       FILT_DIN;
   logic                FILT_VIN;
   logic                FILT_CLR;
   logic                FILT_VOUT;
   logic [CNT_W-1:0]    OUT_CNT;
   logic                BUSY;
   logic                DONE;
   logic                TIMEOUT;

   modport slave (
      input  CFG_WE, CFG_ADDR, CFG_DATA, START, ABORT, NSAMP,
             SRC_VALID, SRC_DATA, FILT_VOUT,
      output CFG_ERR, COEF, SRC_READY, FILT_DIN, FILT_VIN, FILT_CLR,
             OUT_CNT, BUSY, DONE, TIMEOUT
   );

   modport master (
      output CFG_WE, CFG_ADDR, CFG_DATA, START, ABORT, NSAMP,
             SRC_VALID, SRC_DATA, FILT_VOUT,
      input  CFG_ERR, COEF, SRC_READY, FILT_DIN, FILT_VIN, FILT_CLR,
             OUT_CNT, BUSY, DONE, TIMEOUT
   );

endinterface

// File: rtl/iir_coef_bank.sv
// Coefficient register file; writes are only legal while the controller is idle.
module iir_coef_bank
   import iir_pkg::*;
#(
   parameter int DW    = iir_pkg::DW,
   parameter int NCOEF = iir_pkg::NCOEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                idle,
   input  logic                we,
   input  logic [AW-1:0]       addr,
   input  logic [DW-1:0]       data,
   output logic                err,
   output logic [NCOEF*DW-1:0] coef
);

   logic [DW-1:0] bank_q [NCOEF];
   logic          addr_ok;
   logic          write_ok;

   assign addr_ok  = int'(addr) < NCOEF;
   assign write_ok = we && idle && addr_ok;

   // NOTE: the bank must read zero after reset, so every entry is a reset flop rather than an unreset RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCOEF; i++) bank_q[i] <= '0;
         err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
         err <= we && !write_ok;
         if (write_ok) bank_q[addr] <= data;
      end
   end

   for (genvar i = 0; i < NCOEF; i++) begin : g_coef
      assign coef[i*DW +: DW] = bank_q[i];
   end

endmodule

// File: rtl/iir_ctrl.sv
// Run controller for the second-order IIR filter: clears the filter, streams a counted
// number of samples into it, waits for the matching outputs and reports completion.
module iir_ctrl
   import iir_pkg::*;
#(
   parameter int DW        = iir_pkg::DW,
   parameter int NCOEF     = iir_pkg::NCOEF,
   parameter int CNT_W     = 16,
   parameter int DRAIN_MAX = 16
) (
   input  logic      CLK,
   input  logic      RST,
   iir_ctrl_if.slave bus
);

   localparam int WW = $clog2(DRAIN_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;
   localparam logic [WW-1:0]    WAIT_ONE  = 1;
   localparam logic [WW-1:0]    WAIT_LAST = WW'(DRAIN_MAX - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] nsamp_q, in_cnt_q, out_cnt_q;
   logic [WW-1:0]    wait_q;
   logic [DW-1:0]    din_q;
   logic             vin_q, abort_clr_q, timeout_q;
   logic             start_acc, abort_acc, hs, last_in;
   logic             drain_done, drain_tmo, count_out;

   assign start_acc  = (state_q == ST_IDLE) && bus.START;
   assign abort_acc  = bus.ABORT && (state_q inside {ST_CLEAR, ST_RUN, ST_DRAIN});
   // An abort in the same cycle as a handshake swallows the sample.
   assign hs         = (state_q == ST_RUN) && bus.SRC_VALID && !bus.ABORT;
   assign last_in    = hs && ((in_cnt_q + CNT_ONE) == nsamp_q);
   assign drain_done = (state_q == ST_DRAIN) && (out_cnt_q == nsamp_q);
   assign drain_tmo  = (state_q == ST_DRAIN) && !drain_done && (wait_q == WAIT_LAST);
   assign count_out  = bus.FILT_VOUT && (state_q inside {ST_RUN, ST_DRAIN}) && (out_cnt_q != '1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: defaulting to the current state first means no path leaves state_d unassigned, so no latch.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (bus.START) state_d = ST_CLEAR;
         ST_CLEAR: if (abort_acc)                       state_d = ST_IDLE;
                   else if (nsamp_q == '0)              state_d = ST_FIN;
                   else                                 state_d = ST_RUN;
         ST_RUN:   if (abort_acc)                       state_d = ST_IDLE;
                   else if (last_in)                    state_d = ST_DRAIN;
         ST_DRAIN: if (abort_acc)                       state_d = ST_IDLE;
                   else if (drain_done || drain_tmo)    state_d = ST_FIN;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.SRC_READY = (state_q == ST_RUN);
      bus.FILT_CLR  = (state_q == ST_CLEAR) || abort_clr_q;
      bus.BUSY      = (state_q != ST_IDLE);
      bus.DONE      = (state_q == ST_FIN);
      bus.FILT_VIN  = vin_q;
      bus.FILT_DIN  = din_q;
      bus.OUT_CNT   = out_cnt_q;
      bus.TIMEOUT   = timeout_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         nsamp_q     <= '0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         wait_q      <= '0;
         din_q       <= '0;
         vin_q       <= 1'b0;
         abort_clr_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         abort_clr_q <= abort_acc;
         vin_q       <= hs;
         if (hs) din_q <= bus.SRC_DATA;
         wait_q <= (state_q == ST_DRAIN) ? wait_q + WAIT_ONE : '0;
         if (start_acc) begin
            nsamp_q   <= bus.NSAMP;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            timeout_q <= 1'b0;
         end else begin
            if (hs)                        in_cnt_q  <= in_cnt_q + CNT_ONE;
            if (count_out)                 out_cnt_q <= out_cnt_q + CNT_ONE;
            if (drain_tmo && !bus.ABORT)   timeout_q <= 1'b1;
         end
      end
   end

   iir_coef_bank #(
      .DW    (DW),
      .NCOEF (NCOEF)
   ) u_coef_bank (
      .clk  (CLK),
      .rst  (RST),
      .idle (state_q == ST_IDLE),
      .we   (bus.CFG_WE),
      .addr (bus.CFG_ADDR),
      .data (bus.CFG_DATA),
      .err  (bus.CFG_ERR),
      .coef (bus.COEF)
   );

endmodule

// File: tb/tb_iir_ctrl.sv
// Randomized bench for iir_ctrl against a transaction-level model of runs and coefficient writes.
module tb_iir_ctrl;
   import iir_pkg::*;

   localparam int CNT_W     = 16;
   localparam int DRAIN_MAX = 16;
   localparam int CW        = NCOEF * DW;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   iir_ctrl_if bus ();

   iir_ctrl #(
      .DW        (DW),
      .NCOEF     (NCOEF),
      .CNT_W     (CNT_W),
      .DRAIN_MAX (DRAIN_MAX)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] coef_m [NCOEF];
   logic [DW-1:0] fwd_q [$];
   int            done_cnt;
   int            clr_cnt;
   logic          filt_en;
   logic          filt_d1;

   // Filter stand-in: echoes FILT_VIN on FILT_VOUT two cycles later when enabled.
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         filt_d1       <= 1'b0;
         bus.FILT_VOUT <= 1'b0;
      end else begin
         filt_d1       <= bus.FILT_VIN && filt_en;
         bus.FILT_VOUT <= filt_d1;
      end
   end

   initial forever begin
      @(negedge CLK);
      if (!RST) begin
         if (bus.FILT_VIN) fwd_q.push_back(bus.FILT_DIN);
         if (bus.DONE)     done_cnt++;
         if (bus.FILT_CLR) clr_cnt++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [CW-1:0] pack_coef();
      logic [CW-1:0] r;
      for (int i = 0; i < NCOEF; i++) r[i*DW +: DW] = coef_m[i];
      return r;
   endfunction

   task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit exp_err;
      exp_err = int'(a) >= NCOEF;
      bus.CFG_WE   = 1'b1;
      bus.CFG_ADDR = a;
      bus.CFG_DATA = d;
      @(posedge CLK); #1;
      bus.CFG_WE = 1'b0;
      if (!exp_err) coef_m[a] = d;
      check("cfg_err", 64'(bus.CFG_ERR), 64'(exp_err));
      check("coef", 64'(bus.COEF), 64'(pack_coef()));
      @(posedge CLK); #1;
      check("cfg_err_pulse", 64'(bus.CFG_ERR), 64'(0));
   endtask

   // One complete run. vpct<0 selects the alternating valid pattern; abort_at<0 means no abort.
   task automatic do_run(input int nsamp, input int vpct, input bit filt_on,
                         input int abort_at, input bit cfg_poke);
      logic [DW-1:0] exp_q [$];
      logic [DW-1:0] d;
      logic [AW-1:0] sa;
      int            k, acc, n, exp_n, exp_oc;
      bit            aborted, rdy, v, ab, cerr, exp_to;

      filt_en = filt_on;
      fwd_q.delete();
      done_cnt = 0;
      clr_cnt  = 0;
      exp_n  = (nsamp == 0) ? 1 : (filt_on ? 4 : DRAIN_MAX);
      exp_to = (nsamp != 0) && !filt_on;
      exp_oc = (nsamp != 0 && filt_on) ? nsamp : 0;

      // START together with a coefficient write: both must take effect.
      sa   = AW'($urandom_range(NCOEF + 2, 0));
      d    = DW'($urandom);
      cerr = int'(sa) >= NCOEF;
      bus.START    = 1'b1;
      bus.NSAMP    = CNT_W'(nsamp);
      bus.CFG_WE   = 1'b1;
      bus.CFG_ADDR = sa;
      bus.CFG_DATA = d;
      @(posedge CLK); #1;
      bus.START  = 1'b0;
      bus.CFG_WE = 1'b0;
      bus.NSAMP  = CNT_W'($urandom);
      if (!cerr) coef_m[sa] = d;
      check("busy_start", 64'(bus.BUSY), 64'(1));
      check("clr_start", 64'(bus.FILT_CLR), 64'(1));
      check("timeout_clr", 64'(bus.TIMEOUT), 64'(0));
      check("out_cnt_clr", 64'(bus.OUT_CNT), 64'(0));
      check("cfg_err_start", 64'(bus.CFG_ERR), 64'(cerr));
      check("coef_start", 64'(bus.COEF), 64'(pack_coef()));

      aborted = 1'b0;
      acc     = 0;
      k       = 1;
      while (acc < nsamp && !aborted && k < 500) begin
         rdy = (k >= 2);
         check("src_ready", 64'(bus.SRC_READY), 64'(rdy));
         v  = (vpct < 0) ? ((k % 2) == 0) : (int'($urandom_range(99, 0)) < vpct);
         d  = DW'($urandom);
         ab = rdy && (abort_at >= 0) && (acc == abort_at);
         if (ab) v = 1'b1;
         bus.SRC_VALID = v;
         bus.SRC_DATA  = d;
         bus.ABORT     = ab;
         bus.START     = 1'($urandom_range(1, 0));
         bus.CFG_WE    = cfg_poke && (k == 3);
         bus.CFG_ADDR  = COEF_B0;
         bus.CFG_DATA  = ~coef_m[0];
         if (rdy && v && !ab) begin
            exp_q.push_back(d);
            acc++;
         end
         @(posedge CLK); #1;
         if (cfg_poke && k == 3) check("cfg_err_busy", 64'(bus.CFG_ERR), 64'(1));
         bus.CFG_WE = 1'b0;
         aborted = ab;
         k++;
      end
      bus.SRC_VALID = 1'b0;
      bus.ABORT     = 1'b0;
      bus.START     = 1'b0;

      if (aborted) begin
         check("abort_clr", 64'(bus.FILT_CLR), 64'(1));
         check("abort_busy", 64'(bus.BUSY), 64'(0));
         check("abort_ready", 64'(bus.SRC_READY), 64'(0));
         @(posedge CLK); #1;
         check("abort_clr_pulse", 64'(bus.FILT_CLR), 64'(0));
      end else begin
         check("accepted", 64'(acc), 64'(nsamp));
         check("drain_ready", 64'(bus.SRC_READY), 64'(0));
         check("drain_busy", 64'(bus.BUSY), 64'(1));
         n = 0;
         while (bus.DONE !== 1'b1 && n < DRAIN_MAX + 8) begin
            @(posedge CLK); #1;
            n++;
         end
         check("drain_cycles", 64'(n), 64'(exp_n));
         check("timeout", 64'(bus.TIMEOUT), 64'(exp_to));
         check("out_cnt", 64'(bus.OUT_CNT), 64'(exp_oc));
         @(posedge CLK); #1;
         check("done_pulse", 64'(bus.DONE), 64'(0));
         check("busy_end", 64'(bus.BUSY), 64'(0));
      end

      repeat (4) @(posedge CLK);
      #1;
      check("done_count", 64'(done_cnt), 64'(aborted ? 0 : 1));
      check("clr_count", 64'(clr_cnt), 64'(aborted ? 2 : 1));
      check("fwd_count", 64'(fwd_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < fwd_q.size(); i++)
         check("fwd_data", 64'(fwd_q[i]), 64'(exp_q[i]));
      check("busy_idle", 64'(bus.BUSY), 64'(0));
      check("coef_run", 64'(bus.COEF), 64'(pack_coef()));
      if (!aborted) begin
         check("out_cnt_hold", 64'(bus.OUT_CNT), 64'(exp_oc));
         check("timeout_hold", 64'(bus.TIMEOUT), 64'(exp_to));
      end
   endtask

   initial begin
      int n_r;
      RST           = 1'b1;
      bus.CFG_WE    = 1'b0;
      bus.CFG_ADDR  = '0;
      bus.CFG_DATA  = '0;
      bus.START     = 1'b0;
      bus.ABORT     = 1'b0;
      bus.NSAMP     = '0;
      bus.SRC_VALID = 1'b0;
      bus.SRC_DATA  = '0;
      filt_en       = 1'b0;
      done_cnt      = 0;
      clr_cnt       = 0;
      for (int i = 0; i < NCOEF; i++) coef_m[i] = '0;

      repeat (2) @(posedge CLK);
      #1;
      check("rst_busy", 64'(bus.BUSY), 64'(0));
      check("rst_done", 64'(bus.DONE), 64'(0));
      check("rst_clr", 64'(bus.FILT_CLR), 64'(0));
      check("rst_vin", 64'(bus.FILT_VIN), 64'(0));
      check("rst_din", 64'(bus.FILT_DIN), 64'(0));
      check("rst_ready", 64'(bus.SRC_READY), 64'(0));
      check("rst_coef", 64'(bus.COEF), 64'(0));
      check("rst_out_cnt", 64'(bus.OUT_CNT), 64'(0));
      check("rst_timeout", 64'(bus.TIMEOUT), 64'(0));
      check("rst_cfg_err", 64'(bus.CFG_ERR), 64'(0));
      RST = 1'b0;
      @(posedge CLK); #1;

      cfg_write(COEF_B0, 12'h100);
      cfg_write(COEF_B1, 12'h200);
      cfg_write(COEF_B2, 12'h100);
      cfg_write(COEF_A1, 12'hF00);
      cfg_write(COEF_A2, 12'h080);
      cfg_write(3'd5, 12'hABC);
      for (int i = 0; i < 6; i++) cfg_write(AW'($urandom_range(7, 0)), DW'($urandom));

      do_run(4, 100, 1'b1, -1, 1'b0);
      do_run(3, -1, 1'b1, -1, 1'b0);
      do_run(2, 100, 1'b0, -1, 1'b0);
      do_run(4, 100, 1'b1, -1, 1'b0);
      do_run(8, 100, 1'b1, 2, 1'b1);
      do_run(0, 100, 1'b1, -1, 1'b0);
      for (int r = 0; r < 8; r++) begin
         n_r = int'($urandom_range(12, 1));
         do_run(n_r, int'($urandom_range(100, 30)), 1'($urandom_range(1, 0)),
                ($urandom_range(3, 0) == 0) ? int'($urandom_range(n_r - 1, 0)) : -1,
                1'($urandom_range(1, 0)));
      end

      // Reset in the middle of a run returns everything, coefficients included, to zero.
      cfg_write(COEF_B0, 12'h123);
      filt_en       = 1'b1;
      bus.START     = 1'b1;
      bus.NSAMP     = CNT_W'(8);
      @(posedge CLK); #1;
      bus.START     = 1'b0;
      bus.SRC_VALID = 1'b1;
      bus.SRC_DATA  = DW'($urandom);
      repeat (3) @(posedge CLK);
      #1;
      check("mid_busy", 64'(bus.BUSY), 64'(1));
      RST = 1'b1;
      #1;
      check("mid_rst_busy", 64'(bus.BUSY), 64'(0));
      check("mid_rst_coef", 64'(bus.COEF), 64'(0));
      check("mid_rst_ready", 64'(bus.SRC_READY), 64'(0));
      check("mid_rst_vin", 64'(bus.FILT_VIN), 64'(0));
      check("mid_rst_out_cnt", 64'(bus.OUT_CNT), 64'(0));
      bus.SRC_VALID = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("post_rst_busy", 64'(bus.BUSY), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iir_ctrl.md
# iir_ctrl

Run controller for the 12-bit second-order IIR filter datapath. Holds the filter's coefficient bank and sequences each processing run: clear the filter state, stream a programmed number of samples from the upstream source into the filter, wait for the matching output valids, then report completion. It sits between the sample source and the filter instance and replaces free-running VIN drive with a counted, handshaked run.

## Interface
Parameters:
- DW, 12, sample and coefficient width
- NCOEF, 5, coefficient count (b0, b1, b2, a1, a2 at addresses 0..4)
- CNT_W, 16, sample counter width
- DRAIN_MAX, 16, max cycles waited in DRAIN for outstanding outputs

Ports:
- CLK  in  1  clock, all logic rising-edge
- RST  in  1  reset, asynchronous, active-high
- CFG_WE  in  1  coefficient write strobe
- CFG_ADDR  in  3  coefficient index
- CFG_DATA  in  DW  coefficient value (two's complement)
- CFG_ERR  out  1  one-cycle pulse on a rejected write
- COEF  out  NCOEF*DW  coefficient bank, index 0 in LSBs
- START  in  1  start-run request
- ABORT  in  1  abort current run
- NSAMP  in  CNT_W  samples in run, sampled on accepted START
- SRC_VALID  in  1  upstream sample valid
- SRC_DATA  in  DW  upstream sample
- SRC_READY  out  1  controller accepts sample
- FILT_DIN  out  DW  sample to filter
- FILT_VIN  out  1  sample valid to filter
- FILT_CLR  out  1  filter delay-line clear pulse
- FILT_VOUT  in  1  filter output valid
- OUT_CNT  out  CNT_W  outputs counted in current run
- BUSY  out  1  high in any state except IDLE
- DONE  out  1  one-cycle pulse at end of run
- TIMEOUT  out  1  sticky: last run ended by drain timeout

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, FIN.
- IDLE: START=1 → latch NSAMP, zero in/out counters, clear TIMEOUT, go CLEAR. START outside IDLE ignored.
- CLEAR: FILT_CLR=1 for exactly one cycle; next state RUN, or FIN if latched NSAMP=0.
- RUN: SRC_READY=1. Each SRC_VALID&SRC_READY cycle increments in_cnt. The cycle in_cnt reaches NSAMP, SRC_READY drops next cycle and state → DRAIN.
- DRAIN: wait cycles counted from entry; out_cnt=NSAMP → FIN; wait reaches DRAIN_MAX first → set TIMEOUT, go FIN.
- FIN: DONE=1 one cycle, → IDLE.
- FILT_VOUT increments OUT_CNT only in RUN and DRAIN; otherwise ignored. OUT_CNT saturates at all-ones and holds its value in IDLE until the next START.
- ABORT in CLEAR/RUN/DRAIN: pulse FILT_CLR next cycle, → IDLE, no DONE. ABORT in IDLE/FIN ignored. ABORT wins over a same-cycle handshake (sample not counted, not forwarded).
- Config: CFG_WE in IDLE with CFG_ADDR<NCOEF writes COEF[addr] next edge. CFG_WE outside IDLE, or addr≥NCOEF: no write, CFG_ERR pulse next cycle. Simultaneous START and valid CFG_WE in IDLE: both take effect.

## Timing
- Reset values: state IDLE, COEF all zero, every output 0, TIMEOUT 0, counters 0.
- FILT_DIN/FILT_VIN registered: handshake at cycle t → FILT_VIN=1 with data at t+1. FILT_DIN holds last value when FILT_VIN=0.
- START at t: BUSY=1 and FILT_CLR=1 at t+1, SRC_READY=1 at t+2.
- SRC_READY is a registered state decode, independent of SRC_VALID.
- COEF updates one cycle after the write; stable throughout a run.
- Reset asserted mid-run: immediate return to reset values, coefficients lost.

## Structure
- Shared package iir_pkg: DW, NCOEF, coefficient address constants (B0..A2), state enum.
- Sub-module iir_coef_bank: register file plus write-error logic. FSM and counters in iir_ctrl.

## Test plan
- Reset, write COEF addr 0..4 = 0x100,0x200,0x100,0xF00,0x080 → COEF bus matches; addr 5 write → CFG_ERR pulse, bank unchanged.
- START NSAMP=4, SRC_VALID always 1, filter model echoes VIN after 2 cycles → exactly 4 FILT_VIN, OUT_CNT=4, DONE once, TIMEOUT=0.
- NSAMP=3 with SRC_VALID gapped 1-0-1-0-1 → 3 samples forwarded in order, SRC_READY low after the third.
- NSAMP=2, filter model never asserts FILT_VOUT → DONE 16 cycles after entering DRAIN, TIMEOUT=1.
- ABORT mid-RUN after 2 of 8 samples → FILT_CLR pulse, BUSY=0, no DONE; CFG_WE during RUN → CFG_ERR pulse, no write.
- START NSAMP=0 → FILT_CLR then DONE, no FILT_VIN.
